fpu_issue_ctrl: RTL and testbench

Sequencing controller for the multi-cycle, non-pipelined floating-point unit that executes F-type ops (add, sub, mul, div, abs, neg).
- Accepts one decoded FP arithmetic op at a time and pulses the FPU start.
- Counts the per-op latency and raises the FP register-file writeback strobe.
- Drives the decode-stage stall for structural (unit busy) and RAW (pending FP destination) hazards.
- Sits between the main decoder / decode stage and the FPU + FP register file.

---
 rtl/fpu_issue_ctrl_if.sv | 29 ++
 rtl/fpu_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// Decode-stage <-> FPU issue controller bus.
// master = decode stage / environment, slave = fpu_issue_ctrl.
interface fpu_issue_ctrl_if;
    // decode-stage request side
    logic       issue_valid;
    logic [3:0] fpu_control;
    logic [4:0] dst;
    logic       src_valid;
    logic [4:0] src_a;
    logic [4:0] src_b;
    // controller response side
    logic       stall_d;
    logic       fpu_start;
    logic [3:0] fpu_op;
    logic       busy;
    logic       wb_valid;
    logic [4:0] wb_dst;
    logic       illegal_op;

    modport master (
        output issue_valid, fpu_control, dst, src_valid, src_a, src_b,
        input  stall_d, fpu_start, fpu_op, busy, wb_valid, wb_dst, illegal_op
    );

    modport slave (
        input  issue_valid, fpu_control, dst, src_valid, src_a, src_b,
        output stall_d, fpu_start, fpu_op, busy, wb_valid, wb_dst, illegal_op
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Sequencing controller for a multi-cycle, non-pipelined FPU.
// Accepts one FP arithmetic op at a time, pulses fpu_start, counts the
// op latency and strobes the FP register-file writeback. Stalls decode
// while the unit is busy or while a source reads the pending destination.
module fpu_issue_ctrl #(
    parameter int unsigned ADDSUB_LAT = 2,
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned DIV_LAT    = 16,
    parameter int unsigned ABSNEG_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    fpu_issue_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] fpu_op_q, fpu_op_d;
    logic [4:0] wb_dst_q, wb_dst_d;
    logic       fpu_start_q, fpu_start_d;
    logic       wb_valid_q, wb_valid_d;
    logic       busy_q, busy_d;
    logic       illegal_q, illegal_d;

    logic       legal;
    logic       pend;
    logic       raw;
    logic       structural;
    logic       stall;
    logic       accept;
    logic [4:0] lat_m1;

    // Latency minus one for the op on the decode bus; loaded into cnt on accept.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        lat_m1 = 5'(ABSNEG_LAT - 1);
        case (bus.fpu_control)
            4'b0000, 4'b0001: lat_m1 = 5'(ADDSUB_LAT - 1);
            4'b0010:          lat_m1 = 5'(MUL_LAT - 1);
            4'b0011:          lat_m1 = 5'(DIV_LAT - 1);
            default:          lat_m1 = 5'(ABSNEG_LAT - 1);
        endcase
    end

    // Hazard detection and the accept decision.
    always_comb begin
        legal      = (bus.fpu_control <= 4'd5);
        pend       = (state_q != S_IDLE);
        raw        = bus.src_valid & pend &
                     ((bus.src_a == wb_dst_q) | (bus.src_b == wb_dst_q));
        structural = bus.issue_valid & ((state_q == S_ISSUE) | (state_q == S_WAIT));
        stall      = raw | structural;
        accept     = bus.issue_valid & legal & ~stall &
                     ((state_q == S_IDLE) | (state_q == S_WB));
    end

    // Next-state, counter and latched-op computation; outputs are derived
    // from the next state so they come straight out of flops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fpu_op_d = fpu_op_q;
        wb_dst_d = wb_dst_q;

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_ISSUE, S_WAIT: begin
                if (cnt_q == 5'd0) begin
                    state_d = S_WB;
                end else begin
                    cnt_d   = cnt_q - 5'd1;
                    state_d = S_WAIT;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Accept overrides: legal in IDLE or WB (back-to-back issue).
        if (accept) begin
            state_d  = S_ISSUE;
            cnt_d    = lat_m1;
            fpu_op_d = bus.fpu_control;
            wb_dst_d = bus.dst;
        end

        fpu_start_d = (state_d == S_ISSUE);
        wb_valid_d  = (state_d == S_WB);
        busy_d      = (state_d != S_IDLE);
        illegal_d   = bus.issue_valid & ~legal;
    end

    // State and registered outputs; async reset drops any in-flight op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            fpu_op_q    <= 4'd0;
            wb_dst_q    <= 5'd0;
            fpu_start_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fpu_op_q    <= fpu_op_d;
            wb_dst_q    <= wb_dst_d;
            fpu_start_q <= fpu_start_d;
            wb_valid_q  <= wb_valid_d;
            busy_q      <= busy_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.stall_d    = stall;
    assign bus.fpu_start  = fpu_start_q;
    assign bus.fpu_op     = fpu_op_q;
    assign bus.busy       = busy_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_dst     = wb_dst_q;
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model
// that tracks the in-flight op by its age since acceptance.
module tb_fpu_issue_ctrl;

    localparam int ADDSUB_LAT = 2;
    localparam int MUL_LAT    = 4;
    localparam int DIV_LAT    = 16;
    localparam int ABSNEG_LAT = 1;

    logic clk;
    logic reset;

    fpu_issue_ctrl_if bus ();

    fpu_issue_ctrl #(
        .ADDSUB_LAT (ADDSUB_LAT),
        .MUL_LAT    (MUL_LAT),
        .DIV_LAT    (DIV_LAT),
        .ABSNEG_LAT (ABSNEG_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one op in flight, aged 1..lat+1 cycles after accept.
    // age 1 is the start cycle, age lat+1 the writeback cycle.
    bit         m_inflight;
    int         m_age;
    int         m_lat;
    logic [3:0] m_op;
    logic [4:0] m_dst;
    bit         m_ill;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int lat_of(input logic [3:0] op);
        case (op)
            4'd0, 4'd1: return ADDSUB_LAT;
            4'd2:       return MUL_LAT;
            4'd3:       return DIV_LAT;
            default:    return ABSNEG_LAT;
        endcase
    endfunction

    task automatic model_reset();
        m_inflight = 1'b0;
        m_age      = 0;
        m_lat      = 0;
        m_op       = '0;
        m_dst      = '0;
        m_ill      = 1'b0;
    endtask

    task automatic drive(input bit iv, input logic [3:0] ctrl, input logic [4:0] d,
                         input bit sv, input logic [4:0] a, input logic [4:0] b);
        bus.issue_valid = iv;
        bus.fpu_control = ctrl;
        bus.dst         = d;
        bus.src_valid   = sv;
        bus.src_a       = a;
        bus.src_b       = b;
    endtask

    // One clock: compare all outputs at the falling edge, then advance the
    // model with the inputs sampled at the rising edge.
    task automatic step();
        bit exp_stall;
        bit exp_start;
        bit exp_wb;
        bit legal;
        bit accept;
        @(negedge clk);
        exp_start = m_inflight && (m_age == 1);
        exp_wb    = m_inflight && (m_age == m_lat + 1);
        exp_stall = (bus.src_valid && m_inflight &&
                     (bus.src_a == m_dst || bus.src_b == m_dst)) ||
                    (bus.issue_valid && m_inflight && (m_age <= m_lat));
        check("stall_d",    32'(bus.stall_d),    32'(exp_stall));
        check("fpu_start",  32'(bus.fpu_start),  32'(exp_start));
        check("wb_valid",   32'(bus.wb_valid),   32'(exp_wb));
        check("busy",       32'(bus.busy),       32'(m_inflight));
        check("wb_dst",     32'(bus.wb_dst),     32'(m_dst));
        check("fpu_op",     32'(bus.fpu_op),     32'(m_op));
        check("illegal_op", 32'(bus.illegal_op), 32'(m_ill));
        @(posedge clk);
        legal  = (bus.fpu_control <= 4'd5);
        accept = bus.issue_valid && legal && !exp_stall &&
                 (!m_inflight || m_age == m_lat + 1);
        m_ill  = bus.issue_valid && !legal;
        if (accept) begin
            m_inflight = 1'b1;
            m_age      = 1;
            m_lat      = lat_of(bus.fpu_control);
            m_op       = bus.fpu_control;
            m_dst      = bus.dst;
        end else if (m_inflight) begin
            if (m_age == m_lat + 1) m_inflight = 1'b0;
            else m_age++;
        end
        #1;
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs must clear at once.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_fpu_start",  32'(bus.fpu_start),  32'd0);
        check("rst_wb_valid",   32'(bus.wb_valid),   32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_illegal_op", 32'(bus.illegal_op), 32'd0);
        check("rst_fpu_op",     32'(bus.fpu_op),     32'd0);
        check("rst_wb_dst",     32'(bus.wb_dst),     32'd0);
        check("rst_stall_d",    32'(bus.stall_d),    32'd0);
        model_reset();
        @(posedge clk);
        #3 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 4'd0, 5'd0, 0, 5'd0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_busy",     32'(bus.busy),     32'd0);
        check("init_wb_valid", 32'(bus.wb_valid), 32'd0);
        #2 reset = 1'b0;
        repeat (2) step();

        // 1: async reset mid-cycle, then add dst=3.
        drive(1, 4'd0, 5'd3, 0, 5'd0, 5'd0);
        step();
        step();
        do_reset();
        drive(1, 4'd0, 5'd3, 0, 5'd0, 5'd0);
        step();
        drive(0, 4'd0, 5'd0, 0, 5'd0, 5'd0);
        repeat (4) step();

        // 2: div dst=5, second add presented from C2 until accepted at C17.
        drive(1, 4'd3, 5'd5, 0, 5'd0, 5'd0);
        step();
        drive(0, 4'd0, 5'd0, 0, 5'd0, 5'd0);
        step();
        drive(1, 4'd0, 5'd9, 0, 5'd0, 5'd0);
        repeat (16) step();
        drive(0, 4'd0, 5'd0, 0, 5'd0, 5'd0);
        repeat (5) step();

        // 3: RAW on pending div dst=5 through WB, then unrelated sources.
        drive(1, 4'd3, 5'd5, 0, 5'd0, 5'd0);
        step();
        drive(0, 4'd0, 5'd0, 1, 5'd5, 5'd0);
        repeat (18) step();
        drive(1, 4'd3, 5'd5, 0, 5'd0, 5'd0);
        step();
        drive(0, 4'd0, 5'd0, 1, 5'd6, 5'd7);
        repeat (18) step();
        drive(0, 4'd0, 5'd0, 0, 5'd0, 5'd0);
        step();

        // 4: abs dst=1 then neg dst=2 back-to-back.
        drive(1, 4'd4, 5'd1, 0, 5'd0, 5'd0);
        step();
        drive(1, 4'd5, 5'd2, 0, 5'd0, 5'd0);
        repeat (2) step();
        drive(0, 4'd0, 5'd0, 0, 5'd0, 5'd0);
        repeat (3) step();

        // 5: illegal op 0111.
        drive(1, 4'd7, 5'd4, 0, 5'd0, 5'd0);
        step();
        drive(0, 4'd0, 5'd0, 0, 5'd0, 5'd0);
        repeat (3) step();

        // 6: reset during mul WAIT, then add accepted right after release.
        drive(1, 4'd2, 5'd8, 0, 5'd0, 5'd0);
        step();
        drive(0, 4'd0, 5'd0, 0, 5'd0, 5'd0);
        step();
        do_reset();
        drive(1, 4'd0, 5'd10, 0, 5'd0, 5'd0);
        step();
        drive(0, 4'd0, 5'd0, 0, 5'd0, 5'd0);
        repeat (6) step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [3:0] ctrl;
            r    = $urandom_range(0, 15);
            ctrl = (r < 10) ? 4'(r % 6) : 4'(r);
            drive($urandom_range(0, 1), ctrl, 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)));
            if ($urandom_range(0, 199) == 0) do_reset();
            else step();
        end

        drive(0, 4'd0, 5'd0, 0, 5'd0, 5'd0);
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
